// File: rtl/cost_arb_pkg.sv
// rtl/cost_arb_pkg.sv - shared types, widths and round-robin pick function for the cost port arbiter
package cost_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int COST_W  = 7;
    localparam int IDX_W   = 3;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walk offsets from high to low so the requester nearest ptr is the last (winning) assignment.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 nreq);
        pick_t r;
        int    k;
        r = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < nreq) begin
                k = int'(ptr) + i;
                if (k >= nreq) begin
                    k = k - nreq;
                end
                if (req[k]) begin
                    r.found = 1'b1;
                    r.idx   = k[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_nreq.sv
// rtl/rr_pick_nreq.sv - combinational rotate-priority picker for the idle-state grant
module rr_pick_nreq
    import cost_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            found_o,
    output logic [IDW-1:0]  idx_o
);

    pick_t pick;
    logic  unused_idx;

    always_comb begin
        pick = rr_pick(MAX_REQ'(req_i), IDX_W'(ptr_i), NREQ);
    end

    assign found_o    = pick.found;
    assign idx_o      = pick.idx[IDW-1:0];
    assign unused_idx = ^pick.idx;

endmodule

// File: rtl/cost_port_arbiter.sv
// rtl/cost_port_arbiter.sv - burst round-robin arbiter sharing one cost lookup port, 2-cycle pipeline
// Optional per-requester burst counters enabled by COST_ARB_PERF_EN.
module cost_port_arbiter
    import cost_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_last,
    input  logic [3*NREQ-1:0]   req_w,
    input  logic [3*NREQ-1:0]   req_j,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [COST_W-1:0]   rsp_cost,
    output logic [IDX_W-1:0]    W,
    output logic [IDX_W-1:0]    J,
    input  logic [COST_W-1:0]   Cost,
    output logic                busy
`ifdef COST_ARB_PERF_EN
    ,
    input  logic                cnt_clr,
    output logic [16*NREQ-1:0]  gnt_cnt
`endif
);

    arb_state_e        state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    owner_q;
    logic [IDW-1:0]    p_id_q;
    logic              p_v_q;
    logic [IDX_W-1:0]  w_q;
    logic [IDX_W-1:0]  j_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [COST_W-1:0] rsp_cost_q;

    logic              pick_found;
    logic [IDW-1:0]    pick_idx;
    logic [IDW-1:0]    sel;
    logic [IDW-1:0]    ptr_d;
    logic              accept;
    logic              acc_last;

    rr_pick_nreq #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // The burst owner keeps its grant even while it bubbles, so no other engine can interleave.
    always_comb begin
        sel       = (state_q == ARB_BURST) ? owner_q : pick_idx;
        ptr_d     = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
        req_ready = '0;
        if (!RST && (state_q == ARB_BURST || pick_found)) begin
            req_ready[sel] = 1'b1;
        end
        accept    = |(req_ready & req_valid);
        acc_last  = accept && req_last[sel];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            p_v_q       <= 1'b0;
            p_id_q      <= '0;
            w_q         <= '0;
            j_q         <= '0;
            rsp_valid_q <= '0;
            rsp_cost_q  <= '0;
        end else begin
            p_v_q <= accept;
            if (accept) begin
                w_q    <= req_w[IDX_W*int'(sel) +: IDX_W];
                j_q    <= req_j[IDX_W*int'(sel) +: IDX_W];
                p_id_q <= sel;
            end
            rsp_valid_q <= '0;
            if (p_v_q) begin
                rsp_valid_q[p_id_q] <= 1'b1;
                rsp_cost_q          <= Cost;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        if (acc_last) begin
                            ptr_q <= ptr_d;
                        end else begin
                            owner_q <= sel;
                            state_q <= ARB_BURST;
                        end
                    end
                end
                ARB_BURST: begin
                    if (acc_last) begin
                        ptr_q   <= ptr_d;
                        state_q <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign W         = w_q;
    assign J         = j_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_cost  = rsp_cost_q;
    assign busy      = (state_q == ARB_BURST);

`ifdef COST_ARB_PERF_EN
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (cnt_clr) begin
                    cnt_q[k] <= '0;
                end else if (acc_last && sel == IDW'(k) && cnt_q[k] != 16'hFFFF) begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign gnt_cnt[16*g +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_cost_port_arbiter.sv
// tb/tb_cost_port_arbiter.sv - scoreboard bench for cost_port_arbiter (perf test under COST_ARB_PERF_EN)
module tb_cost_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [11:0] req_w;
    logic [11:0] req_j;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [6:0]  rsp_cost;
    logic [2:0]  w_o;
    logic [2:0]  j_o;
    logic [6:0]  cost;
    logic        busy;
`ifdef COST_ARB_PERF_EN
    logic        cnt_clr;
    logic [63:0] gnt_cnt;
`endif

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;

    typedef struct {
        int         id;
        logic [6:0] cost;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    bit         pend;
    logic [2:0] pend_w;
    logic [2:0] pend_j;
    logic [2:0] perm [8] = '{3'd3, 3'd5, 3'd0, 3'd6, 3'd1, 3'd7, 3'd2, 3'd4};

    always #5 CLK = ~CLK;

    // Cost table model: cost = 10 + W
    assign cost = 7'd10 + {4'd0, w_o};

    cost_port_arbiter #(
        .NREQ (4),
        .IDW  (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_w     (req_w),
        .req_j     (req_j),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_cost  (rsp_cost),
        .W         (w_o),
        .J         (j_o),
        .Cost      (cost),
        .busy      (busy)
`ifdef COST_ARB_PERF_EN
        ,
        .cnt_clr   (cnt_clr),
        .gnt_cnt   (gnt_cnt)
`endif
    );

    always @(negedge CLK) begin
        cyc++;
        if ($countones(req_ready) > 1) begin
            tests_run++;
            fails++;
            $display("FAIL ready_onehot: req_ready=%b", req_ready);
        end
        if (pend) begin
            tests_run++;
            if (w_o !== pend_w || j_o !== pend_j) begin
                fails++;
                $display("FAIL wj_load: W=%0d J=%0d expected W=%0d J=%0d", w_o, j_o, pend_w, pend_j);
            end
            pend = 1'b0;
        end
        if (sb.size() > 0 && sb[0].cyc + 2 == cyc) begin
            mon_e = sb.pop_front();
            tests_run++;
            if (rsp_valid !== (4'b0001 << mon_e.id) || rsp_cost !== mon_e.cost) begin
                fails++;
                $display("FAIL rsp: rsp_valid=%b rsp_cost=%0d expected rsp_valid=%b rsp_cost=%0d",
                         rsp_valid, rsp_cost, 4'b0001 << mon_e.id, mon_e.cost);
            end
        end else if (rsp_valid !== 4'b0000) begin
            tests_run++;
            fails++;
            $display("FAIL rsp_spurious: rsp_valid=%b expected 0000", rsp_valid);
        end
        for (int k = 0; k < 4; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                mon_e.id   = k;
                mon_e.cost = 7'd10 + {4'd0, req_w[3*k +: 3]};
                mon_e.cyc  = cyc;
                sb.push_back(mon_e);
                pend   = 1'b1;
                pend_w = req_w[3*k +: 3];
                pend_j = req_j[3*k +: 3];
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input bit l, input int w, input int j);
        req_valid[k]      = v;
        req_last[k]       = l;
        req_w[3*k +: 3]   = 3'(w);
        req_j[3*k +: 3]   = 3'(j);
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        RST       = 1'b1;
        sb.delete();
        pend      = 1'b0;
        step();
        RST       = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        req_last  = '0;
        req_w     = 12'hFFF;
        req_j     = 12'hFFF;
        repeat (2) step();
        tests_run++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: req_ready=%b expected 0000", req_ready);
        end
        tests_run++;
        if (w_o !== 3'd0 || j_o !== 3'd0) begin
            fails++;
            $display("FAIL reset_wj: W=%0d J=%0d expected 0 0", w_o, j_o);
        end
        tests_run++;
        if (rsp_valid !== 4'b0000 || rsp_cost !== 7'd0) begin
            fails++;
            $display("FAIL reset_rsp: rsp_valid=%b rsp_cost=%0d expected 0000 0", rsp_valid, rsp_cost);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
        end
`ifdef COST_ARB_PERF_EN
        tests_run++;
        if (gnt_cnt !== 64'd0) begin
            fails++;
            $display("FAIL reset_cnt: gnt_cnt=%h expected 0", gnt_cnt);
        end
`endif
        req_valid = '0;
        req_w     = '0;
        req_j     = '0;
        RST       = 1'b0;
        step();
    endtask

    task automatic test_single();
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, i == 7, i, int'(perm[i]));
            #1;
            tests_run++;
            if (req_ready !== 4'b0001) begin
                fails++;
                $display("FAIL single_ready[%0d]: req_ready=%b expected 0001", i, req_ready);
            end
            tests_run++;
            if (busy !== (i != 0)) begin
                fails++;
                $display("FAIL single_busy[%0d]: busy=%b expected %b", i, busy, i != 0);
            end
            step();
        end
        set_req(0, 1'b0, 1'b0, 0, 0);
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_busy_end: busy=%b expected 0", busy);
        end
        drain("single");
    endtask

    task automatic test_two_req();
        logic [3:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                set_req(0, 1'b1, c == 7, c, int'(perm[c]));
                set_req(2, 1'b1, 1'b0, 0, 7);
                exp_rdy = 4'b0001;
            end else begin
                set_req(0, 1'b0, 1'b0, 0, 0);
                set_req(2, 1'b1, c == 15, c - 8, 15 - c);
                exp_rdy = 4'b0100;
            end
            #1;
            tests_run++;
            if (req_ready !== exp_rdy) begin
                fails++;
                $display("FAIL two_req_ready[%0d]: req_ready=%b expected %b", c, req_ready, exp_rdy);
            end
            tests_run++;
            if (busy !== (c != 0 && c != 8)) begin
                fails++;
                $display("FAIL two_req_busy[%0d]: busy=%b expected %b", c, busy, c != 0 && c != 8);
            end
            step();
        end
        set_req(2, 1'b0, 1'b0, 0, 0);
        drain("two_req");
    endtask

    task automatic test_wrap();
        logic [3:0] exp_rdy;
        set_req(0, 1'b1, 1'b1, 1, 2);
        set_req(3, 1'b1, 1'b1, 6, 5);
        for (int c = 0; c < 4; c++) begin
            exp_rdy = (c % 2 == 0) ? 4'b1000 : 4'b0001;
            #1;
            tests_run++;
            if (req_ready !== exp_rdy || busy !== 1'b0) begin
                fails++;
                $display("FAIL wrap_grant[%0d]: req_ready=%b busy=%b expected %b 0", c, req_ready, busy, exp_rdy);
            end
            step();
        end
        req_valid = '0;
        req_last  = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL idle_ready[%0d]: req_ready=%b expected 0000", c, req_ready);
            end
            step();
        end
        set_req(0, 1'b1, 1'b1, 3, 3);
        set_req(2, 1'b1, 1'b1, 4, 4);
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL idle_ptr_hold: req_ready=%b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        req_last  = '0;
        drain("wrap");
    endtask

    task automatic test_bubble();
        do_reset();
        set_req(3, 1'b1, 1'b1, 5, 2);
        for (int c = 0; c < 11; c++) begin
            if (c < 3) begin
                set_req(1, 1'b1, 1'b0, c, int'(perm[c]));
            end else if (c < 6) begin
                set_req(1, 1'b0, 1'b1, 7, 7);
            end else begin
                set_req(1, 1'b1, c == 10, c - 3, int'(perm[c - 3]));
            end
            #1;
            tests_run++;
            if (req_ready !== 4'b0010 || busy !== (c != 0)) begin
                fails++;
                $display("FAIL bubble_ready[%0d]: req_ready=%b busy=%b expected 0010 %b", c, req_ready, busy, c != 0);
            end
            step();
        end
        set_req(1, 1'b0, 1'b0, 0, 0);
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL bubble_next_grant: req_ready=%b expected 1000", req_ready);
        end
        step();
        set_req(3, 1'b0, 1'b0, 0, 0);
        drain("bubble");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1'b1, 1'b0, i, int'(perm[i]));
            step();
        end
        RST  = 1'b1;
        sb.delete();
        pend = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0000 || w_o !== 3'd0 || j_o !== 3'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL mid_reset: rsp_valid=%b W=%0d J=%0d busy=%b req_ready=%b expected 0000 0 0 0 0000",
                     rsp_valid, w_o, j_o, busy, req_ready);
        end
        step();
        RST = 1'b0;
        set_req(0, 1'b1, 1'b1, 2, 3);
        #1;
        tests_run++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_regrant: req_ready=%b busy=%b expected 0001 0", req_ready, busy);
        end
        step();
        set_req(0, 1'b0, 1'b0, 0, 0);
        drain("reset_mid");
    endtask

`ifdef COST_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int bu = 0; bu < 3; bu++) begin
            for (int b = 0; b < 2; b++) begin
                set_req(2, 1'b1, b == 1, b, b);
                step();
            end
        end
        set_req(2, 1'b0, 1'b0, 0, 0);
        step();
        tests_run++;
        if (gnt_cnt !== 64'h0000_0003_0000_0000) begin
            fails++;
            $display("FAIL perf_count: gnt_cnt=%h expected 0000000300000000", gnt_cnt);
        end
        set_req(2, 1'b1, 1'b0, 0, 0);
        step();
        set_req(2, 1'b1, 1'b1, 1, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        set_req(2, 1'b0, 1'b0, 0, 0);
        tests_run++;
        if (gnt_cnt !== 64'd0) begin
            fails++;
            $display("FAIL perf_clear: gnt_cnt=%h expected 0", gnt_cnt);
        end
        drain("perf");
    endtask
`endif

    initial begin
        req_valid = '0;
        req_last  = '0;
        req_w     = '0;
        req_j     = '0;
        pend      = 1'b0;
`ifdef COST_ARB_PERF_EN
        cnt_clr   = 1'b0;
`endif
        #1 RST = 1'b1;
        test_reset();
        test_single();
        test_two_req();
        test_wrap();
        test_bubble();
        test_reset_mid();
`ifdef COST_ARB_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
